// File: rtl/alu_issue_ctrl_if.sv
// Handshake/bus bundle for alu_issue_ctrl: two requester ports, the ALU
// operand/result path, the response port and status outputs.
// slave = controller side, master = surrounding logic (issue, ALU, consumer).
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_acc;
  logic [WIDTH-1:0] alu_data;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;

  logic             busy;
  logic [15:0]      stat_cnt0;
  logic [15:0]      stat_cnt1;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_acc, alu_data, alu_opcode,
    output rsp_valid, rsp_id, rsp_result,
    output busy, stat_cnt0, stat_cnt1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_acc, alu_data, alu_opcode,
    input  rsp_valid, rsp_id, rsp_result,
    input  busy, stat_cnt0, stat_cnt1
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin issue of one operation at a time from two
// requesters to a shared accumulator ALU, waiting ALU_LAT cycles for the
// result and returning it over a valid/ready response port.
// Optional per-requester accept counters: define ALU_ISSUE_CTRL_STATS_EN.
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic            execlk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic             rdy0;
  logic             rdy1;
  logic             accept;

  // Grant selection: a lone valid requester wins, otherwise the pointer decides
  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ptr_q;
    else                                  gnt_id = bus.req1_valid;
  end

  // Readies are gated by rst_n so nothing is accepted while reset is held
  assign rdy0   = rst_n & (state_q == ST_IDLE) & gnt_vld & ~gnt_id;
  assign rdy1   = rst_n & (state_q == ST_IDLE) & gnt_vld &  gnt_id;
  assign accept = rdy0 | rdy1;

  // Next-state and datapath updates for the IDLE/WAIT/RESP sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    data_d      = data_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d    = gnt_id ? bus.req1_a  : bus.req0_a;
          data_d   = gnt_id ? bus.req1_b  : bus.req0_b;
          op_d     = gnt_id ? bus.req1_op : bus.req0_op;
          rsp_id_d = gnt_id;
          ptr_d    = ~gnt_id;
          cnt_d    = 4'(ALU_LAT);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          result_d    = bus.alu_result;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge execlk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      data_q      <= '0;
      op_q        <= '1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      result_q    <= result_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.alu_acc    = acc_q;
  assign bus.alu_data   = data_q;
  assign bus.alu_opcode = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = result_q;
  assign bus.busy       = (state_q != ST_IDLE);

`ifdef ALU_ISSUE_CTRL_STATS_EN
  logic [15:0] stat0_q;
  logic [15:0] stat1_q;

  // Saturating per-requester accept counters
  always_ff @(posedge execlk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (rdy0 && (stat0_q != '1)) stat0_q <= stat0_q + 16'd1;
      if (rdy1 && (stat1_q != '1)) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign bus.stat_cnt0 = stat0_q;
  assign bus.stat_cnt1 = stat1_q;
`else
  assign bus.stat_cnt0 = '0;
  assign bus.stat_cnt1 = '0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Arbitrates the single shared 32-bit accumulator ALU between two requesters using round-robin priority.
- Sequences each operation: accept the request, drive the ALU operand and opcode inputs, wait the ALU's registered latency, capture the result and return it through a valid/ready response port.
- Sits between the decode/issue logic and the ALU. The ALU runs on the same execlk.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32: operand and result width.
- OPW, 4: opcode width.
- ALU_LAT, 1: execlk cycles from the ALU sampling its inputs to its result being stable; must be 1..15.

Ports:
- execlk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  OPW  requester 0 opcode.
- req0_a  in  WIDTH  requester 0 accumulator operand.
- req0_b  in  WIDTH  requester 0 data operand.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 accepted this cycle.
- req1_op  in  OPW  requester 1 opcode.
- req1_a  in  WIDTH  requester 1 accumulator operand.
- req1_b  in  WIDTH  requester 1 data operand.
- alu_acc  out  WIDTH  to ALU first operand (registered).
- alu_data  out  WIDTH  to ALU second operand (registered).
- alu_opcode  out  OPW  to ALU opcode (registered).
- alu_result  in  WIDTH  from ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- busy  out  1  high whenever state is not IDLE.
- stat_cnt0  out  16  requester 0 op count (optional feature).
- stat_cnt1  out  16  requester 1 op count (optional feature).

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- Reset values:
  - alu_acc=0, alu_data=0, alu_opcode=all ones (ALU NOP).
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - Priority pointer=0 (requester 0 favoured). Wait counter=0. Stat counters=0.
- Ready signals are combinational: reqN_ready = (state==IDLE) and reqN_valid and grant==N.
  - At most one ready is high in any cycle.
  - Ready is never high outside IDLE.
- Grant in IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester named by the priority pointer is granted.
- Accept edge (IDLE with a grant):
  - Latch the granted op, a and b into alu_opcode, alu_acc and alu_data.
  - Latch rsp_id = granted index.
  - Load the wait counter with ALU_LAT and go to WAIT.
  - Set the priority pointer to the index of the requester not granted.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, capture alu_result into rsp_result, set rsp_valid=1 and go to RESP.
  - Net timing: rsp_valid rises exactly ALU_LAT+1 edges after the accept edge (2 edges at default).
- alu_* outputs hold stable from the accept edge until the next accept; they are not changed in IDLE, WAIT or RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_result hold until the edge with rsp_ready=1.
  - On that edge clear rsp_valid and go to IDLE.
  - A new request cannot be accepted on the response-handshake edge; the earliest accept is the following edge.
- No arithmetic is performed here; result width is passed through unchanged. Opcode values are not checked.
- Requester valid deasserting before accept is legal; no grant occurs for it.
- rsp_ready is ignored outside RESP.
- Asynchronous reset mid-operation:
  - Immediately return to reset values; the in-flight operation and its response are discarded.
  - No ready is high while rst_n=0.

Optional Feature:
- Macro: ALU_ISSUE_CTRL_STATS_EN.
- Defined:
  - stat_cnt0 and stat_cnt1 increment by 1 on each accept edge of the respective requester.
  - Counters saturate at 16'hFFFF and clear only on reset.
- Undefined: stat_cnt0 and stat_cnt1 are tied to 0 and no counter flops are built. Port list is unchanged.

Test Plan:
- Reset, then req0 valid with op=0 (ADD), a=5, b=7 -> req0_ready high in the first cycle. alu_acc=5, alu_data=7, alu_opcode=0 after the edge. rsp_valid=1, rsp_id=0, rsp_result=12 exactly 2 edges after accept.
- Both requesters valid continuously: req0 SUB 10-3, req1 ADD 1+1, rsp_ready held 1 -> grants alternate 0,1,0,1. Responses are 7, 2, 7, 2 with rsp_id 0, 1, 0, 1. Never two readys in one cycle.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_id stay stable. Both readys stay 0 and busy=1. Releasing rsp_ready returns to IDLE one edge later.
- ALU_LAT=3 build, a=32'hFFFFFFFF, b=1, ADD -> rsp_result=0 exactly 4 edges after accept. The wrap-around passes through unchanged.
- Assert rst_n=0 asynchronously while in WAIT -> rsp_valid=0, busy=0, alu_opcode=4'hF immediately. After release, req1 is served first when only it is valid.
- With ALU_ISSUE_CTRL_STATS_EN defined, issue 3 req0 and 2 req1 ops -> stat_cnt0=3, stat_cnt1=2. Without the macro, both read 0.
